// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-op arbiter slice: op-code constants and op field width.
// Optional statistics counters are enabled with LOGIC_ARB_STATS_EN (see logic_unit_arbiter.sv).
package logic_unit_arbiter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/logic_unit_arbiter_op_unit.sv
// Combinational bitwise gate bank shared by several blocks.
// Codes 6 and 7 are illegal: the result is forced to zero and err is raised.
module logic_op_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between NREQ requesters, registered tagged result.
// Define LOGIC_ARB_STATS_EN to add saturating grant_cnt / stall_cnt outputs.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [OP_W-1:0]       rsp_op,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ptr_nxt;
  logic             gnt_found;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] unit_y;
  logic             unit_err;

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign xfer       = !rst && can_accept && gnt_found;
  assign req_ready  = xfer ? (NREQ'(1) << gnt_idx) : '0;
  assign ptr_nxt    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  assign sel_a  = req_a[WIDTH*gnt_idx +: WIDTH];
  assign sel_b  = req_b[WIDTH*gnt_idx +: WIDTH];
  assign sel_op = req_op[OP_W*gnt_idx +: OP_W];

  logic_op_unit #(.WIDTH(WIDTH)) u_op_unit (
    .a   (sel_a),
    .b   (sel_b),
    .op  (sel_op),
    .y   (unit_y),
    .err (unit_err)
  );

  // A new transfer takes priority over the response drain so back-to-back issue keeps rsp_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_op    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (xfer) begin
      ptr_q     <= ptr_nxt;
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_op    <= sel_op;
      rsp_data  <= unit_y;
      rsp_err   <= unit_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer && grant_cnt != CNT_MAX)
        grant_cnt <= grant_cnt + 16'd1;
      if (!xfer && (|req_valid) && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed plan steps plus randomized traffic against a behavioural model.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [3*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_a = '0;
  logic [WIDTH*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [2:0]            rsp_op;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]           grant_cnt;
  logic [15:0]           stall_cnt;
  int                    m_gcnt;
  int                    m_scnt;
`endif

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int               m_ptr = 0;
  bit               m_valid = 0;
  int               m_id = 0;
  int               m_op = 0;
  logic [WIDTH-1:0] m_data = '0;
  bit               m_err = 0;
  logic [NREQ-1:0]  obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_gate(input int op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  function automatic int exp_grant();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input int op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i]            = v;
    req_op[3*i +: 3]        = op[2:0];
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle_check();
    int g;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_op",    32'(rsp_op),    32'(m_op));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_err",   32'(rsp_err),   32'(m_err));
`ifdef LOGIC_ARB_STATS_EN
    chk("grant_cnt", 32'(grant_cnt), 32'(m_gcnt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`endif
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_op = 0; m_data = '0; m_err = 0;
    end else if (g >= 0) begin
      m_op    = int'(req_op[3*g +: 3]);
      m_data  = ref_gate(m_op, req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
      m_err   = (m_op > 5);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
`ifdef LOGIC_ARB_STATS_EN
    if (rst) begin
      m_gcnt = 0; m_scnt = 0;
    end else if (g >= 0) begin
      if (m_gcnt < 65535) m_gcnt++;
    end else if (|req_valid) begin
      if (m_scnt < 65535) m_scnt++;
    end
`endif
    #1;
  endtask

  logic [WIDTH-1:0] op_tbl [6];
  logic [WIDTH-1:0] held;
  logic [NREQ-1:0]  one;

  initial begin
    op_tbl[0] = 4'b1000; op_tbl[1] = 4'b1110; op_tbl[2] = 4'b0111;
    op_tbl[3] = 4'b0001; op_tbl[4] = 4'b0110; op_tbl[5] = 4'b1001;
    one = 1;
`ifdef LOGIC_ARB_STATS_EN
    m_gcnt = 0; m_scnt = 0;
`endif

    // Reset, then one op per cycle from requester 0
    rst = 1'b1;
    cycle_check();
    cycle_check();
    rst = 1'b0;
    for (int op = 0; op < 6; op++) begin
      set_req(0, 1'b1, op, 4'b1100, 4'b1010);
      cycle_check();
      chk("single_grant", 32'(obs_ready), 32'h1);
      chk("single_data",  32'(rsp_data),  32'(op_tbl[op]));
      chk("single_id",    32'(rsp_id),    32'h0);
      chk("single_valid", 32'(rsp_valid), 32'h1);
    end
    req_valid = '0;
    cycle_check();

    // Round-robin from a fresh pointer
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i % 6, 4'(i), 4'(~i));
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle_check();
      chk("rr_grant", 32'(obs_ready), 32'(one << (c % NREQ)));
      chk("rr_id",    32'(rsp_id),    32'(c % NREQ));
    end

    // Backpressure with a pending result
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    held = rsp_data;
    for (int c = 0; c < 5; c++) begin
      cycle_check();
      chk("bp_ready", 32'(obs_ready), 32'h0);
      chk("bp_hold",  32'(rsp_data),  32'(held));
    end
    rsp_ready = 1'b1;
    cycle_check();
    chk("bp_release", 32'(obs_ready), 32'b0010);

    // Illegal op then a legal one
    req_valid = '0;
    set_req(0, 1'b1, 7, 4'hF, 4'hF);
    cycle_check();
    chk("illegal_err",  32'(rsp_err),  32'h1);
    chk("illegal_data", 32'(rsp_data), 32'h0);
    set_req(0, 1'b1, 0, 4'hF, 4'hF);
    cycle_check();
    chk("legal_err",  32'(rsp_err),  32'h0);
    chk("legal_data", 32'(rsp_data), 32'hF);

    // Reset while a result is pending
    req_valid = '0;
    rsp_ready = 1'b0;
    cycle_check();
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cycle_check();
    chk("rst_ptr_grant", 32'(obs_ready), 32'h1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                4'($urandom), 4'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      cycle_check();
    end
    rst = 1'b0;

`ifdef LOGIC_ARB_STATS_EN
    // 4 transfers and 3 stall cycles
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    cycle_check();
    rsp_ready = 1'b0;
    repeat (3) cycle_check();
    rsp_ready = 1'b1;
    repeat (3) cycle_check();
    req_valid = '0;
    chk("stats_grant", 32'(grant_cnt), 32'd4);
    chk("stats_stall", 32'(stall_cnt), 32'd3);

    // Saturation
    rst = 1'b1;
    cycle_check();
    rst = 1'b0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stats_sat", 32'(grant_cnt), 32'hFFFF);
    req_valid = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
